jk_bank_driver: RTL and testbench

- Command-driven controller that drives a bank of WIDTH external JK flip-flops to a requested state.
- Uses JK excitation rules: J/K are derived from the current flop state and the target.
- After driving, it checks the flops' feedback outputs against the expected value, retries on mismatch, and reports done or err.
- Sits between a control/sequencer block and the jk_ff storage bank: the command side of the flops, where the converter blocks are the storage side.

---
 rtl/jk_bank_driver.sv | 163 ++++++++++++++++
 tb/tb_jk_bank_driver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_driver.sv
// jk_bank_driver
// Command-driven controller for a bank of external JK flip-flops. A command
// (LOAD/SET/CLEAR/TOGGLE) is turned into one cycle of J/K excitation, then the
// flop feedback is compared with the expected word, ending in a done or err pulse.
//
// Optional feature: define JK_DRV_RETRY_EN to re-drive the bank (as a LOAD of
// the expected word from the observed feedback) up to MAX_RETRY times before
// reporting err. Without the macro any mismatch reports err at once and no
// retry counter exists.

module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q_exp,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OpLoad   = 2'b00;
  localparam logic [1:0] OpSet    = 2'b01;
  localparam logic [1:0] OpClear  = 2'b10;
  localparam logic [1:0] OpToggle = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] jNext;
  logic [WIDTH-1:0] kNext;
  logic [WIDTH-1:0] qExpNext;
  logic             doneNext;
  logic             errNext;

`ifdef JK_DRV_RETRY_EN
  localparam int RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  logic [RetryW-1:0] retryCnt;
  logic [RetryW-1:0] retryCntNext;
`endif

  // The requester may only hand over a command while the bank is idle and out of reset.
  assign cmd_ready = (state == IDLE) && rst_n;

  // State register plus the registered J/K, expected word and result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      j     <= '0;
      k     <= '0;
      q_exp <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= stateNext;
      j     <= jNext;
      k     <= kNext;
      q_exp <= qExpNext;
      done  <= doneNext;
      err   <= errNext;
    end
  end

`ifdef JK_DRV_RETRY_EN
  // Counts re-drives of the current command; cleared on each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retryCnt <= '0;
    end else begin
      retryCnt <= retryCntNext;
    end
  end
`endif

  // Next-state logic and JK excitation; J/K are only ever high for the DRIVE cycle.
  always_comb begin
    stateNext = state;
    jNext     = '0;
    kNext     = '0;
    qExpNext  = q_exp;
    doneNext  = 1'b0;
    errNext   = 1'b0;
`ifdef JK_DRV_RETRY_EN
    retryCntNext = retryCnt;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OpLoad: begin
              jNext    = cmd_data & ~q_fb;
              kNext    = ~cmd_data & q_fb;
              qExpNext = cmd_data;
            end
            OpSet: begin
              jNext    = cmd_data & ~q_fb;
              qExpNext = q_fb | cmd_data;
            end
            OpClear: begin
              kNext    = cmd_data & q_fb;
              qExpNext = q_fb & ~cmd_data;
            end
            default: begin
              jNext    = cmd_data;
              kNext    = cmd_data;
              qExpNext = q_fb ^ cmd_data;
            end
          endcase
          stateNext = DRIVE;
`ifdef JK_DRV_RETRY_EN
          retryCntNext = '0;
`endif
        end
      end

      DRIVE: begin
        stateNext = CHECK;
      end

      CHECK: begin
        if (q_fb == q_exp) begin
          doneNext  = 1'b1;
          stateNext = IDLE;
        end else begin
`ifdef JK_DRV_RETRY_EN
          if (retryCnt < RetryMax) begin
            retryCntNext = retryCnt + RetryW'(1);
            jNext        = q_exp & ~q_fb;
            kNext        = ~q_exp & q_fb;
            stateNext    = DRIVE;
          end else begin
            errNext   = 1'b1;
            stateNext = IDLE;
          end
`else
          errNext   = 1'b1;
          stateNext = IDLE;
`endif
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver
// Self-checking bench for jk_bank_driver. An ideal JK flop bank (with an
// optional stuck-at-0 fault mask) closes the feedback loop. Expected results
// are queued at accept time and compared when done/err pulses.
// Honours JK_DRV_RETRY_EN for the fault scenario expectations.

module tb_jk_bank_driver;

  localparam int WIDTH = 4;
  localparam logic [1:0] OpLoad   = 2'b00;
  localparam logic [1:0] OpSet    = 2'b01;
  localparam logic [1:0] OpClear  = 2'b10;
  localparam logic [1:0] OpToggle = 2'b11;

`ifdef JK_DRV_RETRY_EN
  localparam int FaultDrives  = 3;
  localparam int FaultLatency = 7;
`else
  localparam int FaultDrives  = 1;
  localparam int FaultLatency = 3;
`endif

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_exp;
  logic             done;
  logic             err;

  logic [WIDTH-1:0] qModel;
  logic             presetEn;
  logic [WIDTH-1:0] presetVal;
  logic [WIDTH-1:0] stuckZero;

  typedef struct {
    logic [WIDTH-1:0] qExp;
    bit               isErr;
    int               acceptCycle;
    int               expLat;
  } sbEntryT;

  sbEntryT sbQueue[$];
  sbEntryT monEntry;

  int checkCount;
  int errorCount;
  int cycleCount;
  int driveTotal;
  int lastAccept;
  int firstAccept;
  int drivesBefore;

  jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .q_fb     (q_fb),
    .j        (j),
    .k        (k),
    .q_exp    (q_exp),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal JK flop bank driven by the DUT, with presettable state and stuck-at-0 bits.
  always @(posedge clk) begin
    if (presetEn) qModel <= presetVal & ~stuckZero;
    else          qModel <= ((j & ~qModel) | (~k & qModel)) & ~stuckZero;
  end
  assign q_fb = qModel;

  // Free-running cycle counter used for latency and accept spacing.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Counts DRIVE cycles that actually excite the bank.
  always @(negedge clk) if (j != '0) driveTotal <= driveTotal + 1;

  // Scoreboard consumer: every done/err pulse must match the oldest queued command.
  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedPulse", {30'd0, done, err}, 32'd0);
      end else begin
        monEntry = sbQueue.pop_front();
        checkOutput("done", {31'd0, done}, {31'd0, !monEntry.isErr});
        checkOutput("err", {31'd0, err}, {31'd0, monEntry.isErr});
        checkOutput("qExp", {28'd0, q_exp}, {28'd0, monEntry.qExp});
        checkOutput("latency", 32'(cycleCount - monEntry.acceptCycle), 32'(monEntry.expLat));
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] modelQExp(input logic [1:0] op, input logic [WIDTH-1:0] d,
                                                  input logic [WIDTH-1:0] cur);
    case (op)
      OpLoad:  return d;
      OpSet:   return cur | d;
      OpClear: return cur & ~d;
      default: return cur ^ d;
    endcase
  endfunction

  task automatic presetQ(input logic [WIDTH-1:0] v);
    presetVal = v;
    presetEn  = 1'b1;
    @(posedge clk);
    #1 presetEn = 1'b0;
    @(negedge clk);
  endtask

  // Presents a command, waits (bounded) for acceptance, queues the expectation.
  // Returns at the falling edge inside the DRIVE cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] data,
                               input bit keepValid, input bit expErr, input int expLat);
    sbEntryT e;
    int      n;
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("readyTimeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e.qExp        = modelQExp(op, data, q_fb);
    e.isErr       = expErr;
    e.acceptCycle = cycleCount;
    e.expLat      = expLat;
    lastAccept    = cycleCount;
    sbQueue.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!keepValid) cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sbQueue.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sbQueue.size() != 0) begin
      checkOutput("waitTimeout", 32'(sbQueue.size()), 32'd0);
      sbQueue.delete();
    end
  endtask

  task automatic checkJk(input string tag, input logic [WIDTH-1:0] expJ, input logic [WIDTH-1:0] expK);
    checkOutput({tag, "_j"}, {28'd0, j}, {28'd0, expJ});
    checkOutput({tag, "_k"}, {28'd0, k}, {28'd0, expK});
  endtask

  // Main stimulus sequence.
  initial begin
    checkCount = 0;
    errorCount = 0;
    cycleCount = 0;
    driveTotal = 0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = OpLoad;
    cmd_data   = '0;
    presetEn   = 1'b0;
    presetVal  = '0;
    stuckZero  = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    presetQ(4'b0000);
    checkOutput("rstReady", {31'd0, cmd_ready}, 32'd0);
    checkJk("rst", 4'b0000, 4'b0000);
    checkOutput("rstQExp", {28'd0, q_exp}, 32'd0);
    checkOutput("rstDoneErr", {30'd0, done, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("relReady", {31'd0, cmd_ready}, 32'd1);

    // Reset asserted mid-DRIVE: command is lost, no pulses.
    applyStimulus(OpLoad, 4'b0011, 1'b0, 1'b0, 3);
    checkJk("preRst", 4'b0011, 4'b0000);
    rst_n = 1'b0;
    #1;
    checkJk("midRst", 4'b0000, 4'b0000);
    checkOutput("midRstReady", {31'd0, cmd_ready}, 32'd0);
    sbQueue.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("postRstReady", {31'd0, cmd_ready}, 32'd1);
      checkOutput("postRstPulse", {30'd0, done, err}, 32'd0);
    end
    checkOutput("postRstQ", {28'd0, q_fb}, 32'd0);

    // LOAD from 0101 to 0011.
    presetQ(4'b0101);
    applyStimulus(OpLoad, 4'b0011, 1'b0, 1'b0, 3);
    checkJk("load", 4'b0010, 4'b0100);
    @(negedge clk);
    checkJk("loadCheck", 4'b0000, 4'b0000);
    waitDone(20);
    checkOutput("loadQ", {28'd0, q_fb}, {28'd0, 4'b0011});
    checkOutput("loadQExp", {28'd0, q_exp}, {28'd0, 4'b0011});

    // SET / CLEAR / TOGGLE starting from 1000.
    presetQ(4'b1000);
    applyStimulus(OpSet, 4'b0001, 1'b0, 1'b0, 3);
    checkJk("set", 4'b0001, 4'b0000);
    waitDone(20);
    checkOutput("setQ", {28'd0, q_fb}, {28'd0, 4'b1001});
    applyStimulus(OpClear, 4'b1000, 1'b0, 1'b0, 3);
    checkJk("clear", 4'b0000, 4'b1000);
    waitDone(20);
    checkOutput("clearQ", {28'd0, q_fb}, {28'd0, 4'b0001});
    applyStimulus(OpToggle, 4'b1111, 1'b0, 1'b0, 3);
    checkJk("toggle", 4'b1111, 4'b1111);
    waitDone(20);
    checkOutput("toggleQ", {28'd0, q_fb}, {28'd0, 4'b1110});

    // Back-to-back LOADs with cmd_valid held high (q currently 1110).
    applyStimulus(OpLoad, 4'b0101, 1'b1, 1'b0, 3);
    firstAccept = lastAccept;
    checkJk("b2bFirst", 4'b0001, 4'b1010);
    applyStimulus(OpLoad, 4'b1010, 1'b0, 1'b0, 3);
    checkJk("b2bSecond", 4'b1010, 4'b0101);
    checkOutput("b2bSpacing", 32'(lastAccept - firstAccept), 32'd3);
    waitDone(20);
    checkOutput("b2bQ", {28'd0, q_fb}, {28'd0, 4'b1010});

    // No-op LOAD and a zero-mask SET still complete with J=K=0.
    presetQ(4'b0110);
    applyStimulus(OpLoad, 4'b0110, 1'b0, 1'b0, 3);
    checkJk("noop", 4'b0000, 4'b0000);
    @(negedge clk);
    checkJk("noopCheck", 4'b0000, 4'b0000);
    waitDone(20);
    applyStimulus(OpSet, 4'b0000, 1'b0, 1'b0, 3);
    checkJk("zeroMask", 4'b0000, 4'b0000);
    waitDone(20);
    checkOutput("noopQ", {28'd0, q_fb}, {28'd0, 4'b0110});

    // Bit 0 stuck at 0: LOAD 0001 never verifies and ends in err.
    stuckZero = 4'b0001;
    presetQ(4'b0000);
    drivesBefore = driveTotal;
    applyStimulus(OpLoad, 4'b0001, 1'b0, 1'b1, FaultLatency);
    checkJk("fault", 4'b0001, 4'b0000);
    waitDone(40);
    checkOutput("faultDrives", 32'(driveTotal - drivesBefore), 32'(FaultDrives));
    stuckZero = 4'b0000;

    // Bank still usable after an error.
    applyStimulus(OpLoad, 4'b1001, 1'b0, 1'b0, 3);
    checkJk("afterErr", 4'b1001, 4'b0000);
    waitDone(20);
    checkOutput("afterErrQ", {28'd0, q_fb}, {28'd0, 4'b1001});

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
